// File: rtl/sram_port_arbiter.sv
// Two-port round-robin arbiter in front of a single-port SRAM with in-order read return and halt/drain control.
// Optional grant/conflict statistics counters are built when SRAM_ARB_STATS_EN is defined.
module sram_port_arbiter #(
  parameter int ADDR_W   = 8,
  parameter int DATA_W   = 32,
  parameter int READ_LAT = 2
) (
  input  logic                wb_clk_i,
  input  logic                resetn,
  input  logic                halt_req,
  output logic                halted,
  input  logic                req0,
  input  logic                we0,
  input  logic [DATA_W/8-1:0] wmask0,
  input  logic [ADDR_W-1:0]   addr0,
  input  logic [DATA_W-1:0]   wdata0,
  output logic                gnt0,
  output logic                rvalid0,
  output logic [DATA_W-1:0]   rdata0,
  input  logic                req1,
  input  logic                we1,
  input  logic [DATA_W/8-1:0] wmask1,
  input  logic [ADDR_W-1:0]   addr1,
  input  logic [DATA_W-1:0]   wdata1,
  output logic                gnt1,
  output logic                rvalid1,
  output logic [DATA_W-1:0]   rdata1,
  output logic                csb,
  output logic                web,
  output logic [DATA_W/8-1:0] wmask,
  output logic [ADDR_W-1:0]   addr,
  output logic [DATA_W-1:0]   din,
  input  logic [DATA_W-1:0]   dout
`ifdef SRAM_ARB_STATS_EN
  ,
  output logic [15:0]         gnt_cnt0,
  output logic [15:0]         gnt_cnt1,
  output logic [15:0]         conflict_cnt
`endif
);

  localparam int MASK_W = DATA_W / 8;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_HALT  = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic                ptr_q, ptr_d;
  logic                halted_q, halted_d;
  logic                csb_q, csb_d;
  logic                web_q, web_d;
  logic [MASK_W-1:0]   wmask_q, wmask_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   din_q, din_d;
  logic [READ_LAT-1:0] pipe_vld_q, pipe_vld_d;
  logic [READ_LAT-1:0] pipe_id_q, pipe_id_d;
  logic [DATA_W-1:0]   rdata0_q, rdata0_d;
  logic [DATA_W-1:0]   rdata1_q, rdata1_d;

  logic                gnt_any;
  logic                gnt_id;
  logic                sel_we;
  logic [MASK_W-1:0]   sel_wmask;
  logic [ADDR_W-1:0]   sel_addr;
  logic [DATA_W-1:0]   sel_wdata;
  logic                rd_issue;

  // halt_req gates grants in the same cycle it rises, before the FSM leaves RUN.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (state_q == ST_RUN && !halt_req) begin
      if (req0 && req1) begin
        gnt0 = ~ptr_q;
        gnt1 = ptr_q;
      end else begin
        gnt0 = req0;
        gnt1 = req1;
      end
    end
  end

  assign gnt_any   = gnt0 | gnt1;
  assign gnt_id    = gnt1;
  assign sel_we    = gnt_id ? we1    : we0;
  assign sel_wmask = gnt_id ? wmask1 : wmask0;
  assign sel_addr  = gnt_id ? addr1  : addr0;
  assign sel_wdata = gnt_id ? wdata1 : wdata0;
  assign rd_issue  = gnt_any & ~sel_we;

  always_comb begin
    ptr_d   = gnt_any ? ~gnt_id : ptr_q;
    csb_d   = ~gnt_any;
    web_d   = gnt_any ? ~sel_we : 1'b1;
    wmask_d = gnt_any ? sel_wmask : wmask_q;
    addr_d  = gnt_any ? sel_addr  : addr_q;
    din_d   = gnt_any ? sel_wdata : din_q;
  end

  always_comb begin
    pipe_vld_d    = '0;
    pipe_id_d     = '0;
    pipe_vld_d[0] = rd_issue;
    pipe_id_d[0]  = gnt_id;
    for (int i = 1; i < READ_LAT; i++) begin
      pipe_vld_d[i] = pipe_vld_q[i-1];
      pipe_id_d[i]  = pipe_id_q[i-1];
    end
  end

  assign rvalid0 = pipe_vld_q[READ_LAT-1] & ~pipe_id_q[READ_LAT-1];
  assign rvalid1 = pipe_vld_q[READ_LAT-1] &  pipe_id_q[READ_LAT-1];

  // Read data is presented straight from the SRAM on the valid cycle and held afterwards.
  always_comb begin
    rdata0_d = rvalid0 ? dout : rdata0_q;
    rdata1_d = rvalid1 ? dout : rdata1_q;
  end

  assign rdata0 = rdata0_d;
  assign rdata1 = rdata1_d;

  // Drain completes on the cycle the last tag leaves, so halted follows the final rvalid.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN: begin
        if (halt_req) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (!halt_req)               state_d = ST_RUN;
        else if (pipe_vld_d == '0)   state_d = ST_HALT;
      end
      ST_HALT: begin
        if (!halt_req) state_d = ST_RUN;
      end
      default: state_d = ST_RUN;
    endcase
    halted_d = (state_d == ST_HALT);
  end

  always_ff @(posedge wb_clk_i or negedge resetn) begin
    if (!resetn) begin
      state_q    <= ST_RUN;
      ptr_q      <= 1'b0;
      halted_q   <= 1'b0;
      csb_q      <= 1'b1;
      web_q      <= 1'b1;
      wmask_q    <= '0;
      addr_q     <= '0;
      din_q      <= '0;
      pipe_vld_q <= '0;
      pipe_id_q  <= '0;
      rdata0_q   <= '0;
      rdata1_q   <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      halted_q   <= halted_d;
      csb_q      <= csb_d;
      web_q      <= web_d;
      wmask_q    <= wmask_d;
      addr_q     <= addr_d;
      din_q      <= din_d;
      pipe_vld_q <= pipe_vld_d;
      pipe_id_q  <= pipe_id_d;
      rdata0_q   <= rdata0_d;
      rdata1_q   <= rdata1_d;
    end
  end

  assign halted = halted_q;
  assign csb    = csb_q;
  assign web    = web_q;
  assign wmask  = wmask_q;
  assign addr   = addr_q;
  assign din    = din_q;

`ifdef SRAM_ARB_STATS_EN
  logic [15:0] gnt_cnt0_q, gnt_cnt0_d;
  logic [15:0] gnt_cnt1_q, gnt_cnt1_d;
  logic [15:0] conflict_cnt_q, conflict_cnt_d;

  always_comb begin
    gnt_cnt0_d     = gnt_cnt0_q;
    gnt_cnt1_d     = gnt_cnt1_q;
    conflict_cnt_d = conflict_cnt_q;
    if (gnt0 && gnt_cnt0_q != 16'hFFFF) gnt_cnt0_d = gnt_cnt0_q + 16'd1;
    if (gnt1 && gnt_cnt1_q != 16'hFFFF) gnt_cnt1_d = gnt_cnt1_q + 16'd1;
    if (state_q == ST_RUN && req0 && req1 && conflict_cnt_q != 16'hFFFF)
      conflict_cnt_d = conflict_cnt_q + 16'd1;
  end

  always_ff @(posedge wb_clk_i or negedge resetn) begin
    if (!resetn) begin
      gnt_cnt0_q     <= '0;
      gnt_cnt1_q     <= '0;
      conflict_cnt_q <= '0;
    end else begin
      gnt_cnt0_q     <= gnt_cnt0_d;
      gnt_cnt1_q     <= gnt_cnt1_d;
      conflict_cnt_q <= conflict_cnt_d;
    end
  end

  assign gnt_cnt0     = gnt_cnt0_q;
  assign gnt_cnt1     = gnt_cnt1_q;
  assign conflict_cnt = conflict_cnt_q;
`endif

endmodule

// File: doc/sram_port_arbiter.md
SRAM_PORT_ARBITER -- requirements
Module: sram_port_arbiter

Interface
REQ-001 Parameters SHALL be: ADDR_W, default 8, SRAM address width; DATA_W, default 32, data width; READ_LAT, default 2, cycles from grant to read data valid, range 1-4.
REQ-002 Ports SHALL be, one per line (name, direction, width, meaning):
- wb_clk_i  in  1  single clock, all logic on rising edge.
- resetn  in  1  asynchronous active-low reset.
- halt_req  in  1  request to drain and stop issuing.
- halted  out  1  no grant in flight, issue stopped.
- reqN  in  1  (N=0,1) requester N access request.
- weN  in  1  1 = write, 0 = read.
- wmaskN  in  DATA_W/8  byte write mask.
- addrN  in  ADDR_W  word address.
- wdataN  in  DATA_W  write data.
- gntN  out  1  request accepted this cycle.
- rvalidN  out  1  rdataN valid for one cycle.
- rdataN  out  DATA_W  read data.
- csb  out  1  SRAM chip select, active-low.
- web  out  1  SRAM write enable, active-low.
- wmask  out  DATA_W/8  SRAM byte mask.
- addr  out  ADDR_W  SRAM address.
- din  out  DATA_W  SRAM write data.
- dout  in  DATA_W  SRAM read data, valid READ_LAT cycles after issue.

Function
REQ-003 Each cycle the block SHALL grant at most one requester; gntN is combinational from reqN, the priority pointer and state.
REQ-004 Arbitration SHALL be round-robin: a 1-bit pointer selects the preferred requester; after a grant the pointer SHALL point to the other requester; a lone request is granted regardless of the pointer.
REQ-005 A granted access SHALL drive csb, web, wmask, addr and din from registers on the cycle after the grant: csb=0, web=~weN, the remaining outputs copied from requester N.
REQ-006 In cycles with no grant, csb SHALL be 1 and web 1; addr, din and wmask SHALL hold their last values.
REQ-007 Each granted read SHALL enter a READ_LAT-deep tag pipeline (valid bit and requester id); on exit the block SHALL pulse rvalidN for the tagged requester, with rdataN = dout in that cycle.
REQ-008 Back-to-back reads SHALL be supported at one per cycle with no bubbles; read data SHALL be returned in issue order.
REQ-009 Writes SHALL produce no rvalid.
REQ-010 The state machine SHALL have states RUN, DRAIN and HALT.
- RUN -> DRAIN when halt_req=1.
- DRAIN -> HALT when the tag pipeline is empty.
- HALT -> RUN when halt_req=0.
- DRAIN -> RUN when halt_req=0 before the pipeline empties.
REQ-011 In DRAIN and HALT no grants SHALL be issued, and in-flight reads SHALL still complete.
REQ-012 halted SHALL be 1 only in HALT.
REQ-013 If halt_req and reqN rise in the same cycle, the request SHALL NOT be granted.
REQ-014 rdataN SHALL hold its value between rvalidN pulses.

Reset
REQ-015 On resetn=0, asynchronously:
- state=RUN, pointer=0.
- tag pipeline cleared.
- csb=1, web=1.
- wmask, addr, din, rdata0 and rdata1 = 0.
- rvalid0=rvalid1=0, halted=0.
REQ-016 Reset asserted mid-read SHALL discard the read; no rvalid SHALL be produced for it after release.
REQ-017 The first grant after reset release SHALL go to requester 0 when both request.

Configuration
REQ-018 With macro SRAM_ARB_STATS_EN defined, the block SHALL add outputs gnt_cnt0, gnt_cnt1 and conflict_cnt, each 16 bits:
- gnt_cntN counts grants to requester N.
- conflict_cnt counts cycles with both requests active during RUN.
- all three saturate at 16'hFFFF and reset to 0.
REQ-019 Without SRAM_ARB_STATS_EN, these outputs and their counters SHALL NOT exist, and all other behaviour SHALL be identical.

Verification
REQ-020 Single write then read: req0 writes addr 8'h05, data 32'hDEADBEEF, wmask 4'hF; then req0 reads addr 8'h05. Required: csb=0 and web=0 one cycle after the write grant; rvalid0 asserted READ_LAT cycles after the read grant with rdata0=32'hDEADBEEF.
REQ-021 Contention: req0 and req1 held high for 6 cycles. Required: grants alternate 0,1,0,1,0,1 starting with requester 0 after reset.
REQ-022 Pipelined reads: req1 reads addr 0..3 on consecutive cycles. Required: rvalid1 high for 4 consecutive cycles with data in address order; rvalid0 stays 0.
REQ-023 Drain: halt_req=1 while 2 reads are in flight. Required: no further gnt, both rvalid pulses delivered, halted=1 on the cycle after the last rvalid; deasserting halt_req resumes grants on the next cycle.
REQ-024 Reset mid-operation: resetn pulsed low one cycle after a read grant. Required: csb=1 immediately; no rvalid within 5 cycles of release.
REQ-025 With SRAM_ARB_STATS_EN: 10 contending cycles. Required: gnt_cnt0=5, gnt_cnt1=5, conflict_cnt=10; pre-loading a counter to 16'hFFFE and granting 3 more times yields 16'hFFFF.
